hazard_stall_ctrl: RTL and testbench

//  Drives the Control unit's enable input and the pipeline write/flush strobes.

---
 rtl/hazard_stall_ctrl_pkg.sv | 30 +++
 rtl/hazard_stall_ctrl_if.sv | 47 ++++
 rtl/hazard_stall_ctrl_sat_counter.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_ctrl_pkg
//  Purpose  : Shared constants for the hazard/stall controller. Holds the
//             opcode values, the controller state encoding and a helper that
//             reports whether an opcode reads rt as a source operand.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // R-type, store and the two compare-branches all read rt as a source.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_ctrl_if
//  Purpose  : Bundle of pipeline-side signals of the hazard/stall controller.
//             Inputs : id_opcode, id_rs, id_rt, idex_memread, idex_rt,
//                      mem_branch_taken, id_jump, dmem_wait
//             Outputs: pc_write, ifid_write, ctrl_enable, ifid_flush,
//                      idex_flush, exmem_flush, stall_count, flush_count
//             master = pipeline side, slave = controller.
//  Revision : 1.0  initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) ();
    logic [5:0]       id_opcode;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             idex_memread;
    logic [REG_W-1:0] idex_rt;
    logic             mem_branch_taken;
    logic             id_jump;
    logic             dmem_wait;
    logic             pc_write;
    logic             ifid_write;
    logic             ctrl_enable;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_opcode, id_rs, id_rt, idex_memread, idex_rt,
               mem_branch_taken, id_jump, dmem_wait,
        input  pc_write, ifid_write, ctrl_enable, ifid_flush, idex_flush,
               exmem_flush, stall_count, flush_count
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, idex_memread, idex_rt,
               mem_branch_taken, id_jump, dmem_wait,
        output pc_write, ifid_write, ctrl_enable, ifid_flush, idex_flush,
               exmem_flush, stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Event counter that sticks at all-ones instead of wrapping.
//             clk, rst (async, active-high), i_inc (count enable),
//             o_count (current value).
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    output logic      [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_ctrl
//  Purpose  : Produces PC/IF-ID write enables, the Control bubble enable and
//             the pipeline flush strobes. Handles load-use hazards, taken
//             branches (MEM), jumps (ID), multi-cycle load stalls and
//             data-memory wait freezes; counts bubbles and redirects.
//             clk, reset (async, active-high), bus (slave side of
//             hazard_stall_ctrl_if).
//  Revision : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W             = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    hazard_stall_ctrl_if.slave bus
);
    // Remaining-bubble counter only has to hold LOAD_STALL_CYCLES-1.
    localparam int c_SCNT_W = (LOAD_STALL_CYCLES > 2) ? $clog2(LOAD_STALL_CYCLES) : 1;
    localparam logic [c_SCNT_W-1:0] c_CNT_ONE  = c_SCNT_W'(1);
    localparam logic [c_SCNT_W-1:0] c_CNT_LOAD = c_SCNT_W'(LOAD_STALL_CYCLES - 1);

    state_t              r_state;
    logic [c_SCNT_W-1:0] r_cnt;

    state_t              w_eff_state;
    state_t              w_next_state;
    logic [c_SCNT_W-1:0] w_next_cnt;
    logic [REG_W-1:0]    w_idex_rt;
    logic                w_load_use;
    logic                w_pc_write, w_ifid_write, w_ctrl_enable;
    logic                w_ifid_flush, w_idex_flush, w_exmem_flush;
    logic                w_stall_inc, w_flush_inc;

    assign w_idex_rt  = bus.idex_rt;
    assign w_load_use = bus.idex_memread && (w_idex_rt != '0) &&
                        ((w_idex_rt == bus.id_rs) ||
                         (uses_rt(bus.id_opcode) && (w_idex_rt == bus.id_rt)));

    // The freeze lasts exactly as long as dmem_wait: in the cycle it drops,
    // WAIT already behaves like the state it returns to.
    always_comb begin
        w_eff_state = r_state;
        if ((r_state == ST_WAIT) && !bus.dmem_wait) begin
            w_eff_state = (r_cnt != '0) ? ST_STALL : ST_RUN;
        end
    end

    always_comb begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_ctrl_enable = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;

        if (bus.dmem_wait) begin
            // Whole pipe frozen; remaining stall bubbles are kept in r_cnt.
            w_ctrl_enable = 1'b1;
            w_next_state  = ST_WAIT;
        end else if (bus.mem_branch_taken) begin
            w_pc_write    = 1'b1;
            w_ifid_write  = 1'b1;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_flush_inc   = 1'b1;
            w_next_state  = ST_RUN;
            w_next_cnt    = '0;
        end else if (w_eff_state == ST_STALL) begin
            // A jump in ID is not acted on here: ID is held and it is seen again.
            w_stall_inc  = 1'b1;
            w_next_cnt   = r_cnt - c_CNT_ONE;
            w_next_state = (r_cnt == c_CNT_ONE) ? ST_RUN : ST_STALL;
        end else if (bus.id_jump) begin
            w_pc_write    = 1'b1;
            w_ifid_write  = 1'b1;
            w_ctrl_enable = 1'b1;
            w_ifid_flush  = 1'b1;
            w_flush_inc   = 1'b1;
            w_next_state  = ST_RUN;
        end else if (w_load_use) begin
            w_stall_inc = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_next_state = ST_STALL;
                w_next_cnt   = c_CNT_LOAD;
            end else begin
                w_next_state = ST_RUN;
            end
        end else begin
            w_pc_write    = 1'b1;
            w_ifid_write  = 1'b1;
            w_ctrl_enable = 1'b1;
            w_next_state  = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Strobes are forced low for as long as reset is held.
    assign bus.pc_write    = w_pc_write    & ~reset;
    assign bus.ifid_write  = w_ifid_write  & ~reset;
    assign bus.ctrl_enable = w_ctrl_enable & ~reset;
    assign bus.ifid_flush  = w_ifid_flush  & ~reset;
    assign bus.idex_flush  = w_idex_flush  & ~reset;
    assign bus.exmem_flush = w_exmem_flush & ~reset;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_stall_inc),
        .o_count (bus.stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_flush_inc),
        .o_count (bus.flush_count)
    );
endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_stall_ctrl
//  Purpose  : Self-checking bench. Two controllers share one stimulus stream:
//             A (LOAD_STALL_CYCLES=1, CNT_W=16) and B (LOAD_STALL_CYCLES=3,
//             CNT_W=4). A bubble-debt model is checked every cycle, plus
//             hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] t_op;
    logic [4:0] t_rs, t_rt, t_xrt;
    logic       t_mr, t_br, t_j, t_dw;

    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) ifA ();
    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  ifB ();

    assign ifA.id_opcode = t_op;  assign ifB.id_opcode = t_op;
    assign ifA.id_rs = t_rs;      assign ifB.id_rs = t_rs;
    assign ifA.id_rt = t_rt;      assign ifB.id_rt = t_rt;
    assign ifA.idex_memread = t_mr; assign ifB.idex_memread = t_mr;
    assign ifA.idex_rt = t_xrt;   assign ifB.idex_rt = t_xrt;
    assign ifA.mem_branch_taken = t_br; assign ifB.mem_branch_taken = t_br;
    assign ifA.id_jump = t_j;     assign ifB.id_jump = t_j;
    assign ifA.dmem_wait = t_dw;  assign ifB.dmem_wait = t_dw;

    hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .reset(reset), .bus(ifA)
    );
    hazard_stall_ctrl #(.REG_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .bus(ifB)
    );

    // Strobe vector order: {pc_write, ifid_write, ctrl_enable, ifid_flush, idex_flush, exmem_flush}
    logic [5:0] stA, stB;
    assign stA = {ifA.pc_write, ifA.ifid_write, ifA.ctrl_enable, ifA.ifid_flush, ifA.idex_flush, ifA.exmem_flush};
    assign stB = {ifB.pc_write, ifB.ifid_write, ifB.ctrl_enable, ifB.ifid_flush, ifB.idex_flush, ifB.exmem_flush};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pend = bubbles still owed after a load-use hazard; sc/fc = counters.
    typedef struct packed { int pend; int sc; int fc; } mst_t;
    mst_t mA, mB, nA, nB;
    logic [5:0] eA, eB;

    function automatic bit hazard();
        bit ur;
        ur = (t_op == 6'h00) || (t_op == 6'h2B) || (t_op == 6'h04) || (t_op == 6'h05);
        return t_mr && (t_xrt != 0) && ((t_xrt == t_rs) || (ur && (t_xrt == t_rt)));
    endfunction

    function automatic int sat(input int v, input int cmax);
        return (v < cmax) ? v + 1 : v;
    endfunction

    function automatic void mstep(input mst_t s, input int lsc, input int cmax,
                                  output logic [5:0] e, output mst_t n);
        n = s;
        e = 6'b111000;
        if (t_dw) begin
            e = 6'b001000;                 // frozen, debt kept
        end else if (t_br) begin
            e = 6'b110111;
            n.pend = 0;
            n.fc = sat(s.fc, cmax);
        end else if (s.pend > 0) begin
            e = 6'b000000;
            n.pend = s.pend - 1;
            n.sc = sat(s.sc, cmax);
        end else if (t_j) begin
            e = 6'b111100;
            n.fc = sat(s.fc, cmax);
        end else if (hazard()) begin
            e = 6'b000000;
            n.pend = lsc - 1;
            n.sc = sat(s.sc, cmax);
        end
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            mA = '0;
            mB = '0;
            chk("rst_strobes_A", 32'(stA), 32'd0);
            chk("rst_strobes_B", 32'(stB), 32'd0);
            chk("rst_counts_A", {ifA.stall_count, ifA.flush_count}, 32'd0);
            chk("rst_counts_B", 32'({ifB.stall_count, ifB.flush_count}), 32'd0);
        end else begin
            mstep(mA, 1, 65535, eA, nA);
            mstep(mB, 3, 15, eB, nB);
            chk("model_strobes_A", 32'(stA), 32'(eA));
            chk("model_stall_count_A", 32'(ifA.stall_count), mA.sc);
            chk("model_flush_count_A", 32'(ifA.flush_count), mA.fc);
            chk("model_strobes_B", 32'(stB), 32'(eB));
            chk("model_stall_count_B", 32'(ifB.stall_count), mB.sc);
            chk("model_flush_count_B", 32'(ifB.flush_count), mB.fc);
            mA = nA;
            mB = nB;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        t_op = 6'h23; t_rs = 0; t_rt = 0; t_xrt = 0;
        t_mr = 0; t_br = 0; t_j = 0; t_dw = 0;
    endtask

    task automatic ld_use(input logic [4:0] r);
        idle();
        t_mr = 1; t_xrt = r; t_rs = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        tick(); tick();
        #1 chk("RST_strobes_A", 32'(stA), 32'd0);
        reset = 1'b0;
        tick();
        #1 chk("IDLE_A", 32'(stA), 32'b111000);
        tick();

        // Test 1: load-use on rs
        ld_use(5'd2);
        #1 chk("T1_bubble_A", 32'(stA), 32'd0);
        chk("T1_bubble_B", 32'(stB), 32'd0);
        tick();
        idle();
        #1 chk("T1_after_A", 32'(stA), 32'b111000);
        chk("T1_stall_count_A", 32'(ifA.stall_count), 32'd1);
        chk("T1_B_second_bubble", 32'(stB), 32'd0);
        tick(); tick();

        // Test 2: idex_rt=0 never stalls
        ld_use(5'd0); t_op = 6'h00;
        #1 chk("T2_no_stall_A", 32'(stA), 32'b111000);
        chk("T2_no_stall_B", 32'(stB), 32'b111000);
        chk("T1_stall_count_B", 32'(ifB.stall_count), 32'd3);
        tick();

        // rt dependence only counts for opcodes that read rt
        idle(); t_op = 6'h2B; t_mr = 1; t_xrt = 5; t_rt = 5; t_rs = 1;
        #1 chk("SW_rt_stall_A", 32'(stA), 32'd0);
        tick();
        idle(); tick(); tick(); tick();
        t_op = 6'h23; t_mr = 1; t_xrt = 5; t_rt = 5; t_rs = 1;
        #1 chk("LW_rt_nostall_A", 32'(stA), 32'b111000);
        chk("LW_rt_nostall_B", 32'(stB), 32'b111000);
        tick();

        // Test 3: branch beats load-use
        ld_use(5'd2); t_br = 1;
        #1 chk("T3_branch_A", 32'(stA), 32'b110111);
        chk("T3_branch_B", 32'(stB), 32'b110111);
        tick();
        idle();
        #1 chk("T3_stall_count_A", 32'(ifA.stall_count), 32'd2);
        chk("T3_flush_count_A", 32'(ifA.flush_count), 32'd1);
        tick();

        // Jump
        t_j = 1;
        #1 chk("JMP_A", 32'(stA), 32'b111100);
        tick();
        idle();
        #1 chk("JMP_flush_count_A", 32'(ifA.flush_count), 32'd2);
        tick();

        // dmem_wait beats branch; branch acted on once the pipe moves again
        t_dw = 1; t_br = 1;
        #1 chk("DW_over_BR_A", 32'(stA), 32'b001000);
        tick();
        t_dw = 0;
        #1 chk("BR_after_DW_A", 32'(stA), 32'b110111);
        tick();

        // Test 4: 3-cycle stall aborted by branch
        ld_use(5'd4);
        #1 chk("T4_bubble1_B", 32'(stB), 32'd0);
        tick();
        idle();
        #1 chk("T4_bubble2_B", 32'(stB), 32'd0);
        tick();
        t_br = 1;
        #1 chk("T4_flush_B", 32'(stB), 32'b110111);
        tick();
        idle();
        #1 chk("T4_run_B", 32'(stB), 32'b111000);
        chk("T4_stall_count_B", 32'(ifB.stall_count), 32'd8);
        tick();

        // Test 5: dmem_wait for 4 cycles while one bubble is still owed
        ld_use(5'd6);
        tick();
        idle();
        tick();
        t_dw = 1;
        #1 chk("T5_frozen_first_B", 32'(stB), 32'b001000);
        tick(); tick(); tick();
        #1 chk("T5_frozen_last_B", 32'(stB), 32'b001000);
        tick();
        t_dw = 0;
        #1 chk("T5_resume_bubble_B", 32'(stB), 32'd0);
        tick();
        #1 chk("T5_run_B", 32'(stB), 32'b111000);
        chk("T5_stall_count_B", 32'(ifB.stall_count), 32'd11);
        tick();

        // Test 6: saturation at 4 bits, then reset in the middle of a stall
        for (int i = 0; i < 20; i++) begin
            ld_use(5'd3);
            tick();
            idle();
            tick(); tick();
        end
        #1 chk("T6_stall_sat_B", 32'(ifB.stall_count), 32'd15);
        for (int i = 0; i < 20; i++) begin
            t_j = 1;
            tick();
        end
        idle();
        #1 chk("T6_flush_sat_B", 32'(ifB.flush_count), 32'd15);
        tick();
        ld_use(5'd3);
        tick();
        idle();
        #1 chk("T6_in_stall_B", 32'(stB), 32'd0);
        reset = 1'b1;
        #1 chk("T6_reset_strobes_B", 32'(stB), 32'd0);
        chk("T6_reset_stall_B", 32'(ifB.stall_count), 32'd0);
        tick();
        reset = 1'b0;
        #1 chk("T6_run_after_reset_B", 32'(stB), 32'b111000);
        chk("T6_flush_after_reset_B", 32'(ifB.flush_count), 32'd0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
